pitch_glide_ctrl: RTL and testbench
===================================

// Module: pitch_glide_ctrl
// PURPOSE
//  Per-voice key-pitch generator with portamento (glide) slew and pitch bend.
//  Output is fixed-point Q8.8 semitones, feeding the oscillator pitch-ratio stage.
//  Voices are serviced time-multiplexed, one voice per step_en cycle.
//  Each serviced voice moves its current pitch toward its target, adds bend, and clamps.
// PARAMETERS
//  VOICES   8  number of voices
//  V_WIDTH  3  voice index width, clog2(VOICES)
// PORTS
//  sCLK_XVXOSC   in   1        sole clock; all logic on posedge
//  reset         in   1        synchronous, active-high
//  note_on       in   1        1-cycle pulse: new note for voice cur_key_adr
//  cur_key_adr   in   V_WIDTH  voice receiving the note
//  cur_key_val   in   8        MIDI key 0..127; values >127 are clamped to 127
//  pitch_val     in   14       pitch wheel; 8192 = centre
//  step_en       in   1        service voice vx this cycle
//  vx            in   V_WIDTH  voice being serviced
//  synth_data_in in   8        register write data
//  adr           in   2        register address
//  write         in   1        register write strobe
//  read          in   1        register read strobe
//  regdata_out   out  8        register read data, 1-cycle latency
//  pitch_out     out  16       Q8.8 pitch, range 0..0x7FFF
//  pitch_vx      out  V_WIDTH  voice tag for pitch_out
//  pitch_valid   out  1        pitch_out / pitch_vx are valid
// BEHAVIOUR
//  Reset:
//   - all cur[v] = tgt[v] = 0x3C00; last_key = 60
//   - pb_range = 2, glide_rate = 0, glide_mode = 0
//   - pitch_out, pitch_vx, regdata_out, pitch_valid = 0; pipeline flushed
//   - reset mid-stream drops in-flight steps (pitch_valid = 0 the next cycle)
//  Registers:
//   - adr 0: pb_range; writes >24 store 24
//   - adr 1: glide_rate
//   - adr 2: glide_mode[1:0]; value 3 is treated as mode 0
//   - adr 3: reads 0
//   - read on cycle N presents data on cycle N+1
//  note_on (k = clamped key):
//   - mode 0: cur = tgt = k<<8
//   - mode 1: tgt = k<<8; cur unchanged
//   - mode 2: cur = last_key<<8, tgt = k<<8
//   - every mode: last_key = k
//  Stage 1 (step_en on cycle N):
//   - delta = {glide_rate, 4'b0}; glide_rate = 0 means jump (cur = tgt)
//   - cur < tgt: cur = min(cur + delta, tgt)
//   - cur > tgt: cur = max(cur - delta, tgt)
//   - result is written back on cycle N+1, so back-to-back steps of one voice chain correctly
//  Stage 2:
//   - bend = (($signed(pitch_val) - 8192) * pb_range) >>> 5, arithmetic shift
//   - sum = stage-1 output pitch (the value written back) + bend, computed in 18-bit signed
//   - sum < 0 gives 0; sum > 0x7FFF gives 0x7FFF
//  Latency: step_en on cycle N gives pitch_out / pitch_vx / pitch_valid on cycle N+2.
//   pitch_valid is high exactly 1 cycle per step_en.
//  Collision (note_on and step_en for the same voice, same cycle):
//   - the note_on state write wins
//   - that step outputs its slew of the pre-note state; its write-back is discarded
//   - the next step of that voice uses the note_on state
//  pitch_val is sampled at stage 2.
// TESTING
//  1. reset; step_en vx=3, pitch_val=8192 -> cycle N+2: pitch_out=0x3C00, pitch_vx=3, valid=1
//  2. mode 0; note_on v1 key 69; step v1 -> pitch_out=0x4500
//  3. mode 1, rate 16; v0 at 60; note_on key 64; 5 steps -> 0x3D00, 0x3E00, 0x3F00, 0x4000, 0x4000
//  4. pb_range 2, v0 at 60: pitch_val 16383 -> 0x3DFF; pitch_val 0 -> 0x3A00; write pb_range 30, read -> 24
//  5. clamp: key 127, range 24, pitch_val 16383 -> 0x7FFF; key 0, pitch_val 0 -> 0x0000
//  6. mode 0; note_on v2 key 72 and step v2 same cycle -> that output 0x3C00, next step 0x4800; mode 2 note 48 after 72 starts at 0x4800

Source files
------------

// File: rtl/pitch_glide_ctrl.sv
// pitch_glide_ctrl: time-multiplexed per-voice glide slew plus pitch bend, Q8.8 semitone output.
module pitch_glide_ctrl #(
   parameter int VOICES  = 8,
   parameter int V_WIDTH = 3
) (
   input  logic               sCLK_XVXOSC,
   input  logic               reset,
   input  logic               note_on,
   input  logic [V_WIDTH-1:0] cur_key_adr,
   input  logic [7:0]         cur_key_val,
   input  logic [13:0]        pitch_val,
   input  logic               step_en,
   input  logic [V_WIDTH-1:0] vx,
   input  logic [7:0]         synth_data_in,
   input  logic [1:0]         adr,
   input  logic               write,
   input  logic               read,
   output logic [7:0]         regdata_out,
   output logic [15:0]        pitch_out,
   output logic [V_WIDTH-1:0] pitch_vx,
   output logic               pitch_valid
);
   logic [15:0]        cur_q [VOICES];
   logic [15:0]        tgt_q [VOICES];
   logic [6:0]         last_key_q;
   logic [4:0]         pb_range_q;
   logic [7:0]         glide_rate_q;
   logic [1:0]         glide_mode_q;
   logic [15:0]        s1_pitch_q;
   logic [V_WIDTH-1:0] s1_vx_q;
   logic               s1_valid_q;
   logic [7:0]         regdata_q;
   logic [15:0]        pitch_q;
   logic [V_WIDTH-1:0] pitch_vx_q;
   logic               pitch_valid_q;

   logic [6:0]         key;
   logic [1:0]         mode;
   logic [15:0]        cur_v, tgt_v, slew_d, note_cur_d, pitch_d;
   logic [11:0]        delta;
   logic [16:0]        up, dn;
   logic               collide;
   logic signed [19:0] off, prod, bend, sum;
   logic [7:0]         rd_d;

   always_comb begin
      key        = cur_key_val[7] ? 7'd127 : cur_key_val[6:0];
      mode       = (glide_mode_q == 2'd3) ? 2'd0 : glide_mode_q;
      note_cur_d = (mode == 2'd2) ? {1'b0, last_key_q, 8'h00} : {1'b0, key, 8'h00};
      cur_v      = cur_q[vx];
      tgt_v      = tgt_q[vx];
      delta      = {glide_rate_q, 4'b0000};
      up         = {1'b0, cur_v} + {5'b0, delta};
      dn         = {1'b0, cur_v} - {5'b0, delta};
      // dn[16] flags a borrow below zero, which also means we passed the target
      slew_d     = (glide_rate_q == 8'd0 || cur_v == tgt_v) ? tgt_v :
                   (cur_v < tgt_v) ? ((up > {1'b0, tgt_v}) ? tgt_v : up[15:0]) :
                   ((dn[16] || dn[15:0] < tgt_v) ? tgt_v : dn[15:0]);
      collide    = note_on && step_en && (cur_key_adr == vx);
      off        = $signed({6'b0, pitch_val}) - 20'sd8192;
      prod       = off * $signed({15'b0, pb_range_q});
      bend       = prod >>> 5;
      sum        = $signed({4'b0, s1_pitch_q}) + bend;
      pitch_d    = sum[19] ? 16'h0000 : (|sum[18:15]) ? 16'h7FFF : sum[15:0];
      rd_d       = (adr == 2'd0) ? {3'b0, pb_range_q} :
                   (adr == 2'd1) ? glide_rate_q :
                   (adr == 2'd2) ? {6'b0, glide_mode_q} : 8'h00;
   end

   always_ff @(posedge sCLK_XVXOSC) begin
      if (reset) begin
         for (int i = 0; i < VOICES; i++) begin
            cur_q[i] <= 16'h3C00;
            tgt_q[i] <= 16'h3C00;
         end
         last_key_q    <= 7'd60;
         pb_range_q    <= 5'd2;
         glide_rate_q  <= 8'd0;
         glide_mode_q  <= 2'd0;
         s1_pitch_q    <= 16'h0000;
         s1_vx_q       <= '0;
         s1_valid_q    <= 1'b0;
         regdata_q     <= 8'h00;
         pitch_q       <= 16'h0000;
         pitch_vx_q    <= '0;
         pitch_valid_q <= 1'b0;
      end else begin
         if (write && adr == 2'd0) pb_range_q <= (synth_data_in > 8'd24) ? 5'd24 : synth_data_in[4:0];
         if (write && adr == 2'd1) glide_rate_q <= synth_data_in;
         if (write && adr == 2'd2) glide_mode_q <= synth_data_in[1:0];
         regdata_q <= read ? rd_d : 8'h00;
         if (step_en && !collide) cur_q[vx] <= slew_d;
         if (note_on) begin
            if (mode != 2'd1) cur_q[cur_key_adr] <= note_cur_d;
            tgt_q[cur_key_adr] <= {1'b0, key, 8'h00};
            last_key_q         <= key;
         end
         s1_pitch_q    <= slew_d;
         s1_vx_q       <= vx;
         s1_valid_q    <= step_en;
         pitch_q       <= pitch_d;
         pitch_vx_q    <= s1_vx_q;
         pitch_valid_q <= s1_valid_q;
      end
   end

   assign regdata_out = regdata_q;
   assign pitch_out   = pitch_q;
   assign pitch_vx    = pitch_vx_q;
   assign pitch_valid = pitch_valid_q;
endmodule

// File: tb/tb_pitch_glide_ctrl.sv
// tb_pitch_glide_ctrl: directed checks of pitch_glide_ctrl with hand-computed expected values.
module tb_pitch_glide_ctrl;
   logic        clk = 1'b0;
   logic        reset, note_on, step_en, write, read;
   logic [2:0]  cur_key_adr, vx, pitch_vx;
   logic [7:0]  cur_key_val, synth_data_in, regdata_out;
   logic [13:0] pitch_val;
   logic [1:0]  adr;
   logic [15:0] pitch_out;
   logic        pitch_valid;
   int          errors = 0;
   int          checks = 0;

   always #5 clk = ~clk;

   pitch_glide_ctrl dut (
      .sCLK_XVXOSC(clk), .reset(reset), .note_on(note_on), .cur_key_adr(cur_key_adr),
      .cur_key_val(cur_key_val), .pitch_val(pitch_val), .step_en(step_en), .vx(vx),
      .synth_data_in(synth_data_in), .adr(adr), .write(write), .read(read),
      .regdata_out(regdata_out), .pitch_out(pitch_out), .pitch_vx(pitch_vx),
      .pitch_valid(pitch_valid)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wreg(input logic [1:0] a, input logic [7:0] d);
      @(negedge clk); write = 1'b1; adr = a; synth_data_in = d;
      @(negedge clk); write = 1'b0;
   endtask

   task automatic rreg(input string tag, input logic [1:0] a, input logic [7:0] exp);
      @(negedge clk); read = 1'b1; adr = a;
      @(negedge clk); read = 1'b0;
      chk(tag, {24'b0, regdata_out}, {24'b0, exp});
   endtask

   task automatic note(input logic [2:0] v, input logic [7:0] k);
      @(negedge clk); note_on = 1'b1; cur_key_adr = v; cur_key_val = k;
      @(negedge clk); note_on = 1'b0;
   endtask

   task automatic step_chk(input string tag, input logic [2:0] v, input logic [13:0] pv,
                           input logic [15:0] exp);
      @(negedge clk); step_en = 1'b1; vx = v; pitch_val = pv;
      @(negedge clk); step_en = 1'b0;
      @(negedge clk);
      chk({tag, "_pitch"}, {16'b0, pitch_out}, {16'b0, exp});
      chk({tag, "_vx"}, {29'b0, pitch_vx}, {29'b0, v});
      chk({tag, "_valid"}, {31'b0, pitch_valid}, 32'd1);
      @(negedge clk);
      chk({tag, "_valid_drop"}, {31'b0, pitch_valid}, 32'd0);
   endtask

   initial begin
      logic [15:0] glide_exp [5];
      glide_exp[0] = 16'h3D00; glide_exp[1] = 16'h3E00; glide_exp[2] = 16'h3F00;
      glide_exp[3] = 16'h4000; glide_exp[4] = 16'h4000;
      reset = 1'b1; note_on = 1'b0; step_en = 1'b0; write = 1'b0; read = 1'b0;
      cur_key_adr = '0; vx = '0; cur_key_val = '0; synth_data_in = '0; adr = '0;
      pitch_val = 14'd8192;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      chk("rst_pitch", {16'b0, pitch_out}, 32'h0);
      chk("rst_valid", {31'b0, pitch_valid}, 32'd0);
      chk("rst_regdata", {24'b0, regdata_out}, 32'h0);
      rreg("rst_pb_range", 2'd0, 8'd2);
      rreg("rst_glide_rate", 2'd1, 8'd0);
      rreg("rst_glide_mode", 2'd2, 8'd0);
      step_chk("t1_reset_pitch", 3'd3, 14'd8192, 16'h3C00);
      note(3'd1, 8'd69);
      step_chk("t2_mode0_note", 3'd1, 14'd8192, 16'h4500);
      note(3'd5, 8'd200);
      step_chk("t2_key_clamp", 3'd5, 14'd8192, 16'h7F00);
      wreg(2'd1, 8'd16);
      wreg(2'd2, 8'd1);
      rreg("t3_rate_rd", 2'd1, 8'd16);
      note(3'd0, 8'd64);
      @(negedge clk); step_en = 1'b1; vx = 3'd0; pitch_val = 14'd8192;
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         if (i == 4) step_en = 1'b0;
         if (i >= 1 && i <= 5) begin
            chk($sformatf("t3_glide_%0d", i - 1), {16'b0, pitch_out}, {16'b0, glide_exp[i-1]});
            chk($sformatf("t3_glide_valid_%0d", i - 1), {31'b0, pitch_valid}, 32'd1);
         end
         if (i == 6) chk("t3_glide_valid_end", {31'b0, pitch_valid}, 32'd0);
      end
      step_chk("t4_bend_up", 3'd6, 14'd16383, 16'h3DFF);
      step_chk("t4_bend_down", 3'd6, 14'd0, 16'h3A00);
      wreg(2'd0, 8'd30);
      rreg("t4_pb_clamp", 2'd0, 8'd24);
      rreg("t4_adr3", 2'd3, 8'd0);
      wreg(2'd2, 8'd0);
      note(3'd7, 8'd127);
      step_chk("t5_clamp_hi", 3'd7, 14'd16383, 16'h7FFF);
      note(3'd7, 8'd0);
      step_chk("t5_clamp_lo", 3'd7, 14'd0, 16'h0000);
      wreg(2'd2, 8'd3);
      note(3'd7, 8'd12);
      step_chk("t5_mode3_as_0", 3'd7, 14'd8192, 16'h0C00);
      wreg(2'd2, 8'd0);
      @(negedge clk);
      note_on = 1'b1; cur_key_adr = 3'd2; cur_key_val = 8'd72;
      step_en = 1'b1; vx = 3'd2; pitch_val = 14'd8192;
      @(negedge clk); note_on = 1'b0; step_en = 1'b0;
      @(negedge clk);
      chk("t6_collide_pitch", {16'b0, pitch_out}, 32'h3C00);
      chk("t6_collide_vx", {29'b0, pitch_vx}, 32'd2);
      step_chk("t6_after_collide", 3'd2, 14'd8192, 16'h4800);
      wreg(2'd2, 8'd2);
      note(3'd2, 8'd48);
      step_chk("t6_mode2_start", 3'd2, 14'd8192, 16'h4700);
      @(negedge clk); step_en = 1'b1; vx = 3'd1;
      @(negedge clk); step_en = 1'b0; reset = 1'b1;
      @(negedge clk);
      chk("reset_flush_valid", {31'b0, pitch_valid}, 32'd0);
      @(negedge clk); reset = 1'b0;
      @(negedge clk);
      chk("reset_flush_valid2", {31'b0, pitch_valid}, 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
